button_conditioner: RTL and testbench

Front-end input stage for the dodge game: synchronises, debounces and conditions the raw board push-buttons (right, left, pause, spare) before they reach the player-movement logic and the game controller. It produces clean levels, single-cycle press/release pulses, an auto-repeating step pulse for held direction buttons, and a latched pause state. Everything runs on the undivided board clock, so downstream logic on divided clocks consumes the level and pause outputs, and CLK-domain logic consumes the pulses.

---
 rtl/button_conditioner_if.sv | 30 +++
 rtl/button_conditioner.sv | 162 ++++++++++++++++
 tb/tb_button_conditioner.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Bundles the raw push-button inputs and the conditioned outputs of the button front end.
// The master side drives btn_raw; the slave side (the conditioner) drives everything else.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_step;
    logic             pause_state;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_step,
        input  pause_state
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_step,
        output pause_state
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and conditions the board push-buttons (levels, edge pulses, step, pause).
// Auto-repeat on btn_step is built only when BTN_AUTOREPEAT_EN is defined; otherwise btn_step == btn_press.
module button_conditioner #(
    parameter int N_BTN        = 4,
    parameter int DEB_CYCLES   = 4,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 3,
    parameter int PAUSE_IDX    = 2
) (
    input  logic                 CLK,
    input  logic                 Clear_n,
    button_conditioner_if.slave  bus
);
    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;
    logic [CNT_W-1:0] r_cnt [N_BTN];
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [N_BTN-1:0] r_step;
    logic             r_pause;

    logic [N_BTN-1:0] w_accept;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;

    // A bit is accepted when it has mismatched the level for DEB_CYCLES consecutive cycles.
    always_comb begin
        w_accept  = '0;
        w_press   = '0;
        w_release = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if ((r_s2[i] != r_level[i]) && (r_cnt[i] == CNT_W'(DEB_CYCLES - 1))) begin
                w_accept[i] = 1'b1;
            end else begin
                w_accept[i] = 1'b0;
            end
        end
        w_press   = w_accept & r_s2;
        w_release = w_accept & ~r_s2;
    end

    // Synchroniser, debounce counters, level/edge registers and pause toggle.
    always_ff @(posedge CLK) begin
        if (!Clear_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_pause   <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= bus.btn_raw;
            r_s2      <= r_s1;
            r_level   <= r_level ^ w_accept;
            r_press   <= w_press;
            r_release <= w_release;
            for (int i = 0; i < N_BTN; i++) begin
                if ((r_s2[i] == r_level[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            if (r_press[PAUSE_IDX]) begin
                r_pause <= ~r_pause;
            end else begin
                r_pause <= r_pause;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    rep_state_t      r_state [N_BTN];
    logic [RC_W-1:0] r_rc    [N_BTN];

    // Per-button repeat FSM; an accepted release wins over a repeat step due in the same cycle.
    always_ff @(posedge CLK) begin
        if (!Clear_n) begin
            r_step <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= ST_IDLE;
                r_rc[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                r_step[i] <= 1'b0;
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_press[i]) begin
                            r_step[i]  <= 1'b1;
                            r_rc[i]    <= RC_W'(1);
                            r_state[i] <= ST_DELAY;
                        end else begin
                            r_rc[i]    <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (w_release[i]) begin
                            r_rc[i]    <= '0;
                            r_state[i] <= ST_IDLE;
                        end else if (r_rc[i] == RC_W'(REPEAT_DELAY)) begin
                            r_step[i]  <= 1'b1;
                            r_rc[i]    <= RC_W'(1);
                            r_state[i] <= ST_REPEAT;
                        end else begin
                            r_rc[i]    <= r_rc[i] + RC_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (w_release[i]) begin
                            r_rc[i]    <= '0;
                            r_state[i] <= ST_IDLE;
                        end else if (r_rc[i] == RC_W'(REPEAT_RATE)) begin
                            r_step[i]  <= 1'b1;
                            r_rc[i]    <= RC_W'(1);
                        end else begin
                            r_rc[i]    <= r_rc[i] + RC_W'(1);
                        end
                    end
                    default: begin
                        r_rc[i]    <= '0;
                        r_state[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

    // Without auto-repeat the step output is simply the press pulse.
    always_ff @(posedge CLK) begin
        if (!Clear_n) begin
            r_step <= '0;
        end else begin
            r_step <= w_press;
        end
    end
`endif

    assign bus.btn_level   = r_level;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;
    assign bus.btn_step    = r_step;
    assign bus.pause_state = r_pause;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner; expectations follow BTN_AUTOREPEAT_EN when defined.
module tb_button_conditioner;
    logic CLK = 1'b0;
    logic Clear_n;
    int   checks   = 0;
    int   failures = 0;

    button_conditioner_if #(.N_BTN(4)) bus ();

    button_conditioner #(
        .N_BTN(4), .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .PAUSE_IDX(2)
    ) dut (
        .CLK     (CLK),
        .Clear_n (Clear_n),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        Clear_n     = 1'b0;
        bus.btn_raw = 4'hF;
        tick();
        tick();
        got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_step, bus.pause_state};
        checks++;
        if (got !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", got, 17'd0);
        end
        Clear_n     = 1'b1;
        bus.btn_raw = 4'h0;
        repeat (8) tick();
        got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_step, bus.pause_state};
        checks++;
        if (got !== 17'd0) begin
            failures++;
            $display("FAIL reset_idle got=%h want=%h", got, 17'd0);
        end
    endtask

    task automatic test_clean_press();
        logic [15:0] got, exp;
        bus.btn_raw = 4'b0001;
        for (int e = 0; e <= 8; e++) begin
            tick();
            exp = {(e >= 5) ? 4'b0001 : 4'b0000, (e == 5) ? 4'b0001 : 4'b0000,
                   4'b0000, (e == 5) ? 4'b0001 : 4'b0000};
            got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_step};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL clean_press e=%0d got=%h want=%h", e, got, exp);
            end
        end
        bus.btn_raw = 4'b0000;
        for (int e = 0; e <= 7; e++) begin
            tick();
            exp = {(e < 5) ? 4'b0001 : 4'b0000, 4'b0000,
                   (e == 5) ? 4'b0001 : 4'b0000, 4'b0000};
            got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_step};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL clean_release e=%0d got=%h want=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0]  pat;
        logic [15:0] got, exp;
        int          presses;
        pat     = 8'b1111_0111;
        presses = 0;
        for (int e = 0; e <= 14; e++) begin
            bus.btn_raw[1] = (e <= 7) ? pat[e] : 1'b1;
            tick();
            if (bus.btn_press[1] === 1'b1) presses++;
            exp = {(e >= 9) ? 4'b0010 : 4'b0000, (e == 9) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000};
            got = {bus.btn_level, bus.btn_press, bus.btn_release, 4'b0000};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL bounce e=%0d got=%h want=%h", e, got, exp);
            end
        end
        checks++;
        if (presses !== 1) begin
            failures++;
            $display("FAIL bounce_press_count got=%0d want=%0d", presses, 1);
        end
        bus.btn_raw = 4'b0000;
        repeat (10) tick();
    endtask

    task automatic test_autorepeat();
        logic [15:0] got, exp;
        logic        st;
        bus.btn_raw = 4'b0001;
        for (int e = 0; e <= 40; e++) begin
            if (e == 28) bus.btn_raw = 4'b0000;
            tick();
`ifdef BTN_AUTOREPEAT_EN
            st = (e == 5) || (e >= 15 && e <= 30 && ((e - 15) % 3) == 0);
`else
            st = (e == 5);
`endif
            exp = {(e >= 5 && e < 33) ? 4'b0001 : 4'b0000, (e == 5) ? 4'b0001 : 4'b0000,
                   (e == 33) ? 4'b0001 : 4'b0000, {3'b000, st}};
            got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_step};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL autorepeat e=%0d got=%h want=%h", e, got, exp);
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_pause();
        logic [2:0] got, exp;
        logic       want_pause;
        for (int e = 0; e <= 30; e++) begin
            bus.btn_raw[2] = (e <= 8 || e >= 17) ? 1'b1 : 1'b0;
            tick();
            exp = {(e == 5 || e == 22), (e == 14), 1'b0};
            got = {bus.btn_press[2], bus.btn_release[2], 1'b0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pause_edges e=%0d got=%b want=%b", e, got, exp);
            end
            if (e != 5 && e != 22) begin
                want_pause = (e >= 6 && e <= 21);
                checks++;
                if (bus.pause_state !== want_pause) begin
                    failures++;
                    $display("FAIL pause_state e=%0d got=%b want=%b", e, bus.pause_state, want_pause);
                end
            end
        end
        bus.btn_raw = 4'b0000;
        repeat (12) tick();
    endtask

    task automatic test_midhold_reset();
        logic [16:0] got, exp;
        bus.btn_raw = 4'b0001;
        for (int e = 0; e <= 23; e++) begin
            if (e == 17) Clear_n = 1'b0;
            if (e == 18) Clear_n = 1'b1;
            tick();
            got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_step, bus.pause_state};
            if (e == 16 || e >= 17) begin
                if (e == 16)      exp = {4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
                else if (e == 23) exp = {4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0};
                else              exp = 17'd0;
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL midhold_reset e=%0d got=%h want=%h", e, got, exp);
                end
            end
        end
        bus.btn_raw = 4'b0000;
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, exp;
        bus.btn_raw = 4'b1011;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp = {(e >= 5) ? 4'b1011 : 4'b0000, (e == 5) ? 4'b1011 : 4'b0000,
                   4'b0000, (e == 5) ? 4'b1011 : 4'b0000};
            got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_step};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL multi_press e=%0d got=%h want=%h", e, got, exp);
            end
        end
        bus.btn_raw = 4'b0000;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp = {(e < 5) ? 4'b1011 : 4'b0000, 4'b0000,
                   (e == 5) ? 4'b1011 : 4'b0000, 4'b0000};
            got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_step};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL multi_release e=%0d got=%h want=%h", e, got, exp);
            end
        end
        checks++;
        if (bus.pause_state !== 1'b0) begin
            failures++;
            $display("FAIL multi_pause got=%b want=%b", bus.pause_state, 1'b0);
        end
    endtask

    initial begin
        Clear_n     = 1'b0;
        bus.btn_raw = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_autorepeat();
        test_pause();
        test_midhold_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
